// File: rtl/cam_init_pkg.sv
// ============================================================================
// cam_init_pkg : shared types and constants for the camera bring-up sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package cam_init_pkg;

  typedef enum logic [3:0] {
    OP_W3 = 4'd0,
    OP_W2 = 4'd1,
    OP_R2 = 4'd2
  } op_t;

  localparam logic [15:0] ROM_END     = 16'hFFFF;
  localparam logic [7:0]  ROM_DLY_REG = 8'hFE;

  typedef enum logic [3:0] {
    S_PWR   = 4'd0,
    S_RST   = 4'd1,
    S_PROBE = 4'd2,
    S_FETCH = 4'd3,
    S_DEC   = 4'd4,
    S_DELAY = 4'd5,
    S_WR    = 4'd6,
    S_VFY   = 4'd7,
    S_DONE  = 4'd8,
    S_FAIL  = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_ISSUE = 2'd1,
    T_WAIT  = 2'd2
  } txn_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sccb_txn.sv
// ============================================================================
// sccb_txn : one SCCB transaction (write, or W2+R2 read) over ready/valid
// Rev 1.0
// ============================================================================
`default_nettype none

module sccb_txn
  import cam_init_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  input  logic       rd_i,
  input  logic [6:0] addr_i,
  input  logic [7:0] reg_i,
  input  logic [7:0] data_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  input  logic       sccb_ready_i,
  input  logic [7:0] sccb_data_out_i,
  output logic [6:0] sccb_addr_o,
  output logic [7:0] sccb_reg_o,
  output logic [7:0] sccb_data_in_o,
  output logic [3:0] sccb_op_type_o,
  output logic       sccb_valid_o
);

  txn_state_t st_q, st_d;
  op_t        op_q, op_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] reg_q, reg_d, data_q, data_d, rdata_q, rdata_d;
  logic       valid_q, valid_d, done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= T_IDLE;
      op_q    <= OP_W3;
      addr_q  <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    op_d    = op_q;
    addr_d  = addr_q;
    reg_d   = reg_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (st_q)
      T_IDLE: begin
        if (req_i) begin
          addr_d = addr_i;
          reg_d  = reg_i;
          data_d = data_i;
          op_d   = rd_i ? OP_W2 : OP_W3;
          st_d   = T_ISSUE;
        end
      end
      T_ISSUE: begin
        if (!sccb_ready_i) begin
          valid_d = 1'b1;
          st_d    = T_WAIT;
        end
      end
      T_WAIT: begin
        if (sccb_ready_i) begin
          valid_d = 1'b0;
          // A read is the address-set phase chained straight into the R2 phase
          if (op_q == OP_W2) begin
            op_d = OP_R2;
            st_d = T_ISSUE;
          end else begin
            if (op_q == OP_R2) rdata_d = sccb_data_out_i;
            done_d = 1'b1;
            st_d   = T_IDLE;
          end
        end
      end
      default: st_d = T_IDLE;
    endcase
  end

  assign done_o         = done_q;
  assign rdata_o        = rdata_q;
  assign sccb_addr_o    = addr_q;
  assign sccb_reg_o     = reg_q;
  assign sccb_data_in_o = data_q;
  assign sccb_op_type_o = op_q;
  assign sccb_valid_o   = valid_q;

endmodule

`default_nettype wire

// File: rtl/cam_probe_config_seq.sv
// ============================================================================
// cam_probe_config_seq : camera power-up, sensor probe and ROM-table config
// Rev 1.0
// ============================================================================
`default_nettype none

module cam_probe_config_seq
  import cam_init_pkg::*;
#(
  parameter int                  N_CAMS     = 3,
  parameter logic [7*N_CAMS-1:0] CAM_ADDR   = {7'h3C, 7'h30, 7'h21},
  parameter logic [8*N_CAMS-1:0] CAM_ID_REG = {8'hF0, 8'h0A, 8'h0A},
  parameter logic [8*N_CAMS-1:0] CAM_ID_VAL = {8'h20, 8'h26, 8'h76},
  parameter int                  ROM_AW     = 8,
  parameter int                  WAIT_CYC   = 16000000,
  parameter int                  DLY_UNIT   = 16000,
  parameter int                  VERIFY     = 1,
  parameter int                  MAX_RETRY  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              sccb_ready_i,
  input  logic [7:0]        sccb_data_out_i,
  output logic [6:0]        sccb_addr_o,
  output logic [7:0]        sccb_reg_o,
  output logic [7:0]        sccb_data_in_o,
  output logic [3:0]        sccb_op_type_o,
  output logic              sccb_valid_o,
  output logic [2:0]        rom_sel_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [15:0]       rom_data_i,
  output logic              cam_reset_o,
  output logic [7:0]        cam_id_o,
  output logic              init_ready_o,
  output logic              init_error_o,
  output logic [7:0]        err_cnt_o
);

  localparam int          DW        = $clog2(255 * DLY_UNIT + 1);
  localparam logic [24:0] WAIT_LAST = 25'(WAIT_CYC - 1);

  logic [6:0] w_addr_tab  [8];
  logic [7:0] w_idreg_tab [8];
  logic [7:0] w_idval_tab [8];

  for (genvar g = 0; g < 8; g++) begin : g_cam_tab
    if (g < N_CAMS) begin : g_used
      assign w_addr_tab[g]  = CAM_ADDR[7*g +: 7];
      assign w_idreg_tab[g] = CAM_ID_REG[8*g +: 8];
      assign w_idval_tab[g] = CAM_ID_VAL[8*g +: 8];
    end else begin : g_unused
      assign w_addr_tab[g]  = '0;
      assign w_idreg_tab[g] = '0;
      assign w_idval_tab[g] = '0;
    end
  end

  state_t            state_q, state_d;
  logic [24:0]       wcnt_q, wcnt_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic [2:0]        idx_q, idx_d, rom_sel_q, rom_sel_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]       ent_q, ent_d;
  logic [7:0]        try_q, try_d, err_q, err_d, cam_id_q, cam_id_d;
  logic              pend_q, pend_d;
  logic              adv;

  logic       w_req, w_done;
  logic [7:0] w_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_PWR;
      wcnt_q     <= '0;
      dly_q      <= '0;
      idx_q      <= '0;
      rom_sel_q  <= '0;
      rom_addr_q <= '0;
      ent_q      <= '0;
      try_q      <= '0;
      err_q      <= '0;
      cam_id_q   <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      dly_q      <= dly_d;
      idx_q      <= idx_d;
      rom_sel_q  <= rom_sel_d;
      rom_addr_q <= rom_addr_d;
      ent_q      <= ent_d;
      try_q      <= try_d;
      err_q      <= err_d;
      cam_id_q   <= cam_id_d;
      pend_q     <= pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    dly_d      = dly_q;
    idx_d      = idx_q;
    rom_sel_d  = rom_sel_q;
    rom_addr_d = rom_addr_q;
    ent_d      = ent_q;
    try_d      = try_q;
    err_d      = err_q;
    cam_id_d   = cam_id_q;
    pend_d     = pend_q;
    w_req      = 1'b0;
    adv        = 1'b0;
    case (state_q)
      S_PWR, S_RST: begin
        if (wcnt_q == WAIT_LAST) begin
          wcnt_d  = '0;
          idx_d   = '0;
          pend_d  = 1'b0;
          state_d = (state_q == S_PWR) ? S_RST : S_PROBE;
        end else begin
          wcnt_d = wcnt_q + 25'd1;
        end
      end
      S_PROBE: begin
        if (!pend_q) begin
          w_req  = 1'b1;
          pend_d = 1'b1;
        end else if (w_done) begin
          pend_d = 1'b0;
          if (w_rdata == w_idval_tab[idx_q]) begin
            cam_id_d   = w_rdata;
            rom_sel_d  = idx_q;
            rom_addr_d = '0;
            state_d    = S_FETCH;
          end else if (idx_q < 3'(N_CAMS - 1)) begin
            idx_d = idx_q + 3'd1;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      S_FETCH: state_d = S_DEC;
      S_DEC: begin
        ent_d = rom_data_i;
        if (rom_data_i == ROM_END) begin
          state_d = S_DONE;
        end else if (rom_data_i[15:8] == ROM_DLY_REG) begin
          if (rom_data_i[7:0] == 8'd0) begin
            adv = 1'b1;
          end else begin
            dly_d   = DW'(rom_data_i[7:0]) * DW'(DLY_UNIT);
            state_d = S_DELAY;
          end
        end else begin
          try_d   = 8'd1;
          state_d = S_WR;
        end
      end
      S_DELAY: begin
        if (dly_q <= DW'(1)) adv = 1'b1;
        else                 dly_d = dly_q - DW'(1);
      end
      S_WR: begin
        if (!pend_q) begin
          w_req  = 1'b1;
          pend_d = 1'b1;
        end else if (w_done) begin
          pend_d = 1'b0;
          if (VERIFY != 0) state_d = S_VFY;
          else             adv     = 1'b1;
        end
      end
      S_VFY: begin
        if (!pend_q) begin
          w_req  = 1'b1;
          pend_d = 1'b1;
        end else if (w_done) begin
          pend_d = 1'b0;
          if (w_rdata == ent_q[7:0]) begin
            adv = 1'b1;
          end else if (try_q < 8'(MAX_RETRY)) begin
            try_d   = try_q + 8'd1;
            state_d = S_WR;
          end else begin
            err_d = sat_inc8(err_d);
            adv   = 1'b1;
          end
        end
      end
      S_DONE, S_FAIL: begin
        if (start_i) begin
          state_d  = S_PWR;
          wcnt_d   = '0;
          err_d    = '0;
          cam_id_d = '0;
        end
      end
      default: state_d = S_PWR;
    endcase
    // Running off the end of the table without a terminator counts as an error
    if (adv) begin
      if (rom_addr_q == {ROM_AW{1'b1}}) begin
        err_d   = sat_inc8(err_d);
        state_d = S_DONE;
      end else begin
        rom_addr_d = rom_addr_q + 1'b1;
        state_d    = S_FETCH;
      end
    end
  end

  sccb_txn u_txn (
    .clk             (clk),
    .rst             (rst),
    .req_i           (w_req),
    .rd_i            (state_q != S_WR),
    .addr_i          (w_addr_tab[idx_q]),
    .reg_i           ((state_q == S_PROBE) ? w_idreg_tab[idx_q] : ent_q[15:8]),
    .data_i          (ent_q[7:0]),
    .done_o          (w_done),
    .rdata_o         (w_rdata),
    .sccb_ready_i    (sccb_ready_i),
    .sccb_data_out_i (sccb_data_out_i),
    .sccb_addr_o     (sccb_addr_o),
    .sccb_reg_o      (sccb_reg_o),
    .sccb_data_in_o  (sccb_data_in_o),
    .sccb_op_type_o  (sccb_op_type_o),
    .sccb_valid_o    (sccb_valid_o)
  );

  assign rom_sel_o    = rom_sel_q;
  assign rom_addr_o   = rom_addr_q;
  assign cam_reset_o  = (state_q != S_PWR);
  assign cam_id_o     = cam_id_q;
  assign err_cnt_o    = err_q;
  assign init_ready_o = (state_q == S_DONE) || (state_q == S_FAIL);
  assign init_error_o = (state_q == S_FAIL) || ((state_q == S_DONE) && (err_q != 8'd0));

endmodule

`default_nettype wire

// File: tb/tb_cam_probe_config_seq.sv
// ============================================================================
// tb_cam_probe_config_seq : directed bench with an SCCB slave and ROM model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cam_probe_config_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sccb_ready = 1'b0;
  logic [7:0]  sccb_data_out = 8'd0;
  logic [6:0]  sccb_addr;
  logic [7:0]  sccb_reg, sccb_data_in;
  logic [3:0]  sccb_op_type;
  logic        sccb_valid;
  logic [2:0]  rom_sel;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data = 16'd0;
  logic        cam_reset, init_ready, init_error;
  logic [7:0]  cam_id, err_cnt;

  cam_probe_config_seq #(
    .ROM_AW   (4),
    .WAIT_CYC (8),
    .DLY_UNIT (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start),
    .sccb_ready_i    (sccb_ready),
    .sccb_data_out_i (sccb_data_out),
    .sccb_addr_o     (sccb_addr),
    .sccb_reg_o      (sccb_reg),
    .sccb_data_in_o  (sccb_data_in),
    .sccb_op_type_o  (sccb_op_type),
    .sccb_valid_o    (sccb_valid),
    .rom_sel_o       (rom_sel),
    .rom_addr_o      (rom_addr),
    .rom_data_i      (rom_data),
    .cam_reset_o     (cam_reset),
    .cam_id_o        (cam_id),
    .init_ready_o    (init_ready),
    .init_error_o    (init_error),
    .err_cnt_o       (err_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: 8 banks of 16 entries
  logic [15:0] mem [128];
  always @(posedge clk) rom_data <= mem[{rom_sel, rom_addr}];

  // SCCB slave model configuration and log
  logic [7:0] resp21 = 8'd0, resp30 = 8'd0, resp3c = 8'd0;
  int         corrupt_mode = 0;
  logic       clr_log = 1'b0;
  int         n_w3 = 0, n_w2 = 0, n_r2 = 0, lat = 0, low_run = 0, w3_gap = -1;
  logic [6:0] w2_log [8];
  logic [6:0] w3_addr = 7'd0;
  logic [7:0] regs [256];
  logic [7:0] cur_reg = 8'd0;
  logic [7:0] rd;
  logic       corrupted = 1'b0;

  always @(negedge clk) begin
    if (clr_log) begin
      n_w3 = 0; n_w2 = 0; n_r2 = 0; low_run = 0; w3_gap = -1; corrupted = 1'b0;
      for (int i = 0; i < 256; i++) regs[i] = 8'd0;
    end
    if (rst) begin
      sccb_ready = 1'b0;
      lat = 0;
    end else begin
      if (sccb_valid) begin
        if (low_run > 0 && sccb_op_type == 4'd0 && n_w3 == 0) w3_gap = low_run;
        low_run = 0;
      end else begin
        low_run++;
      end
      if (sccb_valid && !sccb_ready) begin
        lat++;
        if (lat == 2) begin
          sccb_ready = 1'b1;
          case (sccb_op_type)
            4'd0: begin
              n_w3++;
              w3_addr = sccb_addr;
              regs[sccb_reg] = sccb_data_in;
            end
            4'd1: begin
              if (n_w2 < 8) w2_log[n_w2[2:0]] = sccb_addr;
              n_w2++;
              cur_reg = sccb_reg;
            end
            4'd2: begin
              n_r2++;
              if (sccb_addr == 7'h21 && cur_reg == 8'h0A)      rd = resp21;
              else if (sccb_addr == 7'h30 && cur_reg == 8'h0A) rd = resp30;
              else if (sccb_addr == 7'h3C && cur_reg == 8'hF0) rd = resp3c;
              else begin
                rd = regs[cur_reg];
                if (cur_reg == 8'h12 && (corrupt_mode == 1 || (corrupt_mode == 2 && !corrupted))) begin
                  rd = rd ^ 8'h5A;
                  corrupted = 1'b1;
                end
              end
              sccb_data_out = rd;
            end
            default: ;
          endcase
        end
      end else if (!sccb_valid && sccb_ready) begin
        sccb_ready = 1'b0;
        lat = 0;
      end
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    @(negedge clk); #1 clr_log = 1'b1;
    @(negedge clk); #1 clr_log = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 3000 && !init_ready; k++) @(negedge clk);
    check_eq(tag, 32'(init_ready), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input logic want_w3);
    for (int k = 0; k < 3000 && !(sccb_valid && (!want_w3 || sccb_op_type == 4'd0)); k++)
      @(negedge clk);
    check_eq(tag, 32'(sccb_valid), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'hFFFF;
    mem[0] = 16'h1280; mem[1] = 16'h1100; mem[2] = 16'hFFFF;
    mem[32] = 16'hFE05; mem[33] = 16'h1280; mem[34] = 16'hFFFF;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_valid",    32'(sccb_valid), 32'd0);
    check_eq("rst_cam_rst",  32'(cam_reset), 32'd0);
    check_eq("rst_ready",    32'(init_ready), 32'd0);
    check_eq("rst_error",    32'(init_error), 32'd0);
    check_eq("rst_addr",     32'(sccb_addr), 32'd0);
    check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);

    // 1: first candidate answers, two-entry table with verify
    resp21 = 8'h76;
    clear_log();
    @(negedge clk); #1 rst = 1'b0;
    wait_done("s1_done");
    check_eq("s1_error",  32'(init_error), 32'd0);
    check_eq("s1_cam_id", 32'(cam_id), 32'h76);
    check_eq("s1_w3",     n_w3, 32'd2);
    check_eq("s1_w2",     n_w2, 32'd3);
    check_eq("s1_r2",     n_r2, 32'd3);
    check_eq("s1_probe0", 32'(w2_log[0]), 32'h21);
    check_eq("s1_w3addr", 32'(w3_addr), 32'h21);
    check_eq("s1_reg12",  32'(regs[8'h12]), 32'h80);

    // 2: nobody answers
    resp21 = 8'h00;
    clear_log();
    pulse_start();
    check_eq("s2_ready_clr", 32'(init_ready), 32'd0);
    check_eq("s2_id_clr",    32'(cam_id), 32'd0);
    wait_done("s2_done");
    check_eq("s2_error",  32'(init_error), 32'd1);
    check_eq("s2_cam_id", 32'(cam_id), 32'd0);
    check_eq("s2_probes", n_w2, 32'd3);
    check_eq("s2_order",  32'({w2_log[0], w2_log[1], w2_log[2]}), 32'({7'h21, 7'h30, 7'h3C}));
    check_eq("s2_w3",     n_w3, 32'd0);

    // 3: third candidate matches; FE05 gives 20 idle cycles plus 7 of fetch/decode/issue overhead
    resp3c = 8'h20;
    clear_log();
    pulse_start();
    wait_done("s3_done");
    check_eq("s3_error",  32'(init_error), 32'd0);
    check_eq("s3_cam_id", 32'(cam_id), 32'h20);
    check_eq("s3_rom_sel", 32'(rom_sel), 32'd2);
    check_eq("s3_w3",     n_w3, 32'd1);
    check_eq("s3_w3addr", 32'(w3_addr), 32'h3C);
    check_eq("s3_gap",    w3_gap, 32'd27);

    // 4: readback of 0x12 always wrong
    resp3c = 8'h00; resp21 = 8'h76; corrupt_mode = 1;
    mem[1] = 16'hFFFF;
    clear_log();
    pulse_start();
    wait_done("s4_done");
    check_eq("s4_w3",    n_w3, 32'd3);
    check_eq("s4_errc",  32'(err_cnt), 32'd1);
    check_eq("s4_error", 32'(init_error), 32'd1);

    // 5: only the first readback is wrong
    corrupt_mode = 2;
    clear_log();
    pulse_start();
    check_eq("s5_errc_clr", 32'(err_cnt), 32'd0);
    wait_done("s5_done");
    check_eq("s5_w3",    n_w3, 32'd2);
    check_eq("s5_errc",  32'(err_cnt), 32'd0);
    check_eq("s5_error", 32'(init_error), 32'd0);

    // 6: start ignored mid-run, then reset during a transaction
    corrupt_mode = 0;
    mem[1] = 16'h1100;
    clear_log();
    pulse_start();
    wait_valid("s6_w3_seen", 1'b1);
    pulse_start();
    check_eq("s6_start_ign", 32'(cam_reset), 32'd1);
    wait_valid("s6_valid_seen", 1'b0);
    #2 rst = 1'b1;
    #1;
    check_eq("s6_rst_valid", 32'(sccb_valid), 32'd0);
    check_eq("s6_rst_camrst", 32'(cam_reset), 32'd0);
    check_eq("s6_rst_addr",  32'(sccb_addr), 32'd0);
    check_eq("s6_rst_id",    32'(cam_id), 32'd0);
    clear_log();
    @(negedge clk); #1 rst = 1'b0;
    wait_done("s6_done");
    check_eq("s6_w3",     n_w3, 32'd2);
    check_eq("s6_error",  32'(init_error), 32'd0);
    check_eq("s6_cam_id", 32'(cam_id), 32'h76);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
